// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-bin approximate magnitude (max + min/2) and per-frame
// peak search over NBINS consecutive FFT bins, with bin-sequence checking.
// Optional build macro FFT_PEAK_SKIP_DC_EN excludes bin 0 (DC) from the peak
// search while still using it to start and sequence-check the frame.
module fft_peak_detect #(
   parameter int WIDTH = 16,
   parameter int NBINS = 8,
   parameter int IDX_W = 3
) (
   input  logic                    fastclk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   input  logic [IDX_W-1:0]        in_index,
   output logic                    peak_valid,
   output logic [IDX_W-1:0]        peak_index,
   output logic [WIDTH-1:0]        peak_mag,
   output logic                    frame_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

   // |x| as unsigned; the most negative input maps to 2^(WIDTH-1) exactly.
   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
      logic [WIDTH-1:0] u;
      u = x;
      return x[WIDTH-1] ? (~u + WIDTH'(1)) : u;
   endfunction

   // max(a,b) + min(a,b)/2 with a truncating shift; bounded to 1.5*2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] approx_mag(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] hi, lo;
      hi = (a >= b) ? a : b;
      lo = (a >= b) ? b : a;
      return hi + (lo >> 1);
   endfunction

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] exp_idx, exp_nxt;
   logic             ld, upd, done, err;
   logic             ld_max, upd_max;

   logic             vld_p1;
   logic [WIDTH-1:0] a_p1, b_p1;
   logic [IDX_W-1:0] idx_p1;

   logic [WIDTH-1:0] mag_p2;
   logic [IDX_W-1:0] idx_p2;
   logic             ld_p2, upd_p2, done_p2, err_p2;

   logic             done_p3;
   logic [WIDTH-1:0] run_max;
   logic [IDX_W-1:0] run_idx;

   // ---- stage 1: component magnitudes, index and valid registered together
   // Capture |re|, |im| and the bin index for every strobe.
   always_ff @(posedge fastclk) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else        vld_p1 <= in_valid;
      a_p1   <= abs_val(in_re);
      b_p1   <= abs_val(in_im);
      idx_p1 <= in_index;
   end

   // Sequence checker: decide what each stage-1 bin does to the running max.
   always_comb begin
      state_nxt = state;
      exp_nxt   = exp_idx;
      ld        = 1'b0;
      upd       = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      if (vld_p1) begin
         case (state)
            IDLE: begin
               if (idx_p1 == '0) begin
                  ld        = 1'b1;
                  exp_nxt   = IDX_W'(1);
                  state_nxt = ACCUM;
               end
            end
            ACCUM: begin
               if (idx_p1 == exp_idx) begin
                  upd     = 1'b1;
                  exp_nxt = exp_idx + 1'b1;
                  if (idx_p1 == LAST_IDX) begin
                     done      = 1'b1;
                     state_nxt = IDLE;
                  end
               end else if (idx_p1 == '0) begin
                  // premature restart: drop the partial frame, this bin opens a new one
                  err     = 1'b1;
                  ld      = 1'b1;
                  exp_nxt = IDX_W'(1);
               end else begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef FFT_PEAK_SKIP_DC_EN
   // DC only opens the frame; bin 1 seeds the running max.
   assign ld_max  = upd && (idx_p1 == IDX_W'(1));
   assign upd_max = upd && (idx_p1 != IDX_W'(1));
`else
   assign ld_max  = ld;
   assign upd_max = upd;
`endif

   // ---- stage 2: magnitude plus the per-bin action from the sequence checker
   // Register FSM state, per-bin actions and the approximate magnitude.
   always_ff @(posedge fastclk) begin
      if (!rst_n) begin
         state   <= IDLE;
         exp_idx <= '0;
         ld_p2   <= 1'b0;
         upd_p2  <= 1'b0;
         done_p2 <= 1'b0;
         err_p2  <= 1'b0;
      end else begin
         state   <= state_nxt;
         exp_idx <= exp_nxt;
         ld_p2   <= ld_max;
         upd_p2  <= upd_max;
         done_p2 <= done;
         err_p2  <= err;
      end
      mag_p2 <= approx_mag(a_p1, b_p1);
      idx_p2 <= idx_p1;
   end

   // ---- stage 3: running max update, error pulse, completion flag
   // Strict compare so equal magnitudes keep the earlier (lower) bin.
   always_ff @(posedge fastclk) begin
      if (!rst_n) begin
         done_p3   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         done_p3   <= done_p2;
         frame_err <= err_p2;
      end
      if (ld_p2 || (upd_p2 && (mag_p2 > run_max))) begin
         run_max <= mag_p2;
         run_idx <= idx_p2;
      end
   end

   // ---- output register: publish the finished frame's peak, hold otherwise
   // A new frame's bin 0 may load run_max on this same edge; the old value is captured.
   always_ff @(posedge fastclk) begin
      if (!rst_n) begin
         peak_valid <= 1'b0;
         peak_index <= '0;
         peak_mag   <= '0;
      end else begin
         peak_valid <= done_p3;
         if (done_p3) begin
            peak_index <= run_idx;
            peak_mag   <= run_max;
         end
      end
   end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Testbench for fft_peak_detect: scoreboard of expected peak reports and
// frame_err pulses (value and arrival cycle), one task per scenario.
`timescale 1ns/1ps
module tb_fft_peak_detect;

   localparam int WIDTH = 16;
   localparam int NBINS = 8;
   localparam int IDX_W = 3;

   logic                    fastclk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic signed [WIDTH-1:0] in_re = '0;
   logic signed [WIDTH-1:0] in_im = '0;
   logic [IDX_W-1:0]        in_index = '0;
   logic                    peak_valid;
   logic [IDX_W-1:0]        peak_index;
   logic [WIDTH-1:0]        peak_mag;
   logic                    frame_err;

   fft_peak_detect #(.WIDTH(WIDTH), .NBINS(NBINS), .IDX_W(IDX_W)) dut (
      .fastclk    (fastclk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_re      (in_re),
      .in_im      (in_im),
      .in_index   (in_index),
      .peak_valid (peak_valid),
      .peak_index (peak_index),
      .peak_mag   (peak_mag),
      .frame_err  (frame_err)
   );

   always #5 fastclk = ~fastclk;

   typedef struct {int cyc; int idx; int mag;} pk_t;

   pk_t obs_pk[$];
   pk_t exp_pk[$];
   int  obs_err[$];
   int  exp_err[$];
   int  pk_rd = 0;
   int  err_rd = 0;
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;
   int  fr_re[NBINS];
   int  fr_im[NBINS];

   always @(posedge fastclk) cyc <= cyc + 1;

   // Record every output event with the number of rising edges seen so far.
   always @(negedge fastclk) begin
      if (peak_valid === 1'b1) obs_pk.push_back('{cyc, int'(peak_index), int'(peak_mag)});
      if (frame_err === 1'b1) obs_err.push_back(cyc);
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got cycle %0d, want < 50000", cyc);
      $fatal(1, "timeout");
   end

   function automatic int mag_m(input int re, input int im);
      int a, b;
      a = (re < 0) ? -re : re;
      b = (im < 0) ? -im : im;
      return (a >= b) ? a + b / 2 : b + a / 2;
   endfunction

   task automatic send_bin(input int idx, input int re, input int im);
      @(negedge fastclk);
      in_valid = 1'b1;
      in_index = IDX_W'(idx);
      in_re    = WIDTH'(re);
      in_im    = WIDTH'(im);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge fastclk);
         in_valid = 1'b0;
      end
   endtask

   // Drive fr_re/fr_im as one complete frame and queue the model's peak.
   task automatic send_frame_model();
      int first, best, bi, m;
      for (int i = 0; i < NBINS; i++) send_bin(i, fr_re[i], fr_im[i]);
      first = 0;
`ifdef FFT_PEAK_SKIP_DC_EN
      first = 1;
`endif
      best = mag_m(fr_re[first], fr_im[first]);
      bi   = first;
      for (int i = first + 1; i < NBINS; i++) begin
         m = mag_m(fr_re[i], fr_im[i]);
         if (m > best) begin
            best = m;
            bi   = i;
         end
      end
      exp_pk.push_back('{cyc + 4, bi, best});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      n_chk++;
      if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL reset_peak_valid: got %b, want 0", peak_valid); end
      n_chk++;
      if (peak_index !== '0) begin n_fail++; $display("FAIL reset_peak_index: got %0d, want 0", peak_index); end
      n_chk++;
      if (peak_mag !== '0) begin n_fail++; $display("FAIL reset_peak_mag: got %0d, want 0", peak_mag); end
      n_chk++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, want 0", frame_err); end
      @(negedge fastclk);
      rst_n = 1'b1;
      idle(2);
      pk_rd  = obs_pk.size();
      err_rd = obs_err.size();
   endtask

   task automatic test_tie();
      pk_t e, o;
      for (int i = 0; i < NBINS; i++) send_bin(i, 100, 0);
`ifdef FFT_PEAK_SKIP_DC_EN
      exp_pk.push_back('{cyc + 4, 1, 100});
`else
      exp_pk.push_back('{cyc + 4, 0, 100});
`endif
      idle(7);
      n_chk++;
      if (obs_pk.size() - pk_rd !== exp_pk.size()) begin n_fail++; $display("FAIL tie_npeak: got %0d pulses, want %0d", obs_pk.size() - pk_rd, exp_pk.size()); end
      while (exp_pk.size() > 0 && pk_rd < obs_pk.size()) begin
         e = exp_pk.pop_front(); o = obs_pk[pk_rd]; pk_rd++;
         n_chk++;
         if (o.idx !== e.idx || o.mag !== e.mag || o.cyc !== e.cyc) begin n_fail++; $display("FAIL tie_peak: got idx=%0d mag=%0d cyc=%0d, want idx=%0d mag=%0d cyc=%0d", o.idx, o.mag, o.cyc, e.idx, e.mag, e.cyc); end
      end
      n_chk++;
      if (obs_err.size() - err_rd !== 0) begin n_fail++; $display("FAIL tie_nerr: got %0d frame_err, want 0", obs_err.size() - err_rd); end
      pk_rd = obs_pk.size(); err_rd = obs_err.size(); exp_pk.delete();
   endtask

   task automatic test_corner();
      pk_t e, o;
      for (int i = 0; i < NBINS; i++) send_bin(i, (i == 5) ? -32768 : 0, (i == 5) ? -32768 : 0);
      exp_pk.push_back('{cyc + 4, 5, 49152});
      idle(7);
      n_chk++;
      if (obs_pk.size() - pk_rd !== exp_pk.size()) begin n_fail++; $display("FAIL corner_npeak: got %0d pulses, want %0d", obs_pk.size() - pk_rd, exp_pk.size()); end
      while (exp_pk.size() > 0 && pk_rd < obs_pk.size()) begin
         e = exp_pk.pop_front(); o = obs_pk[pk_rd]; pk_rd++;
         n_chk++;
         if (o.idx !== e.idx || o.mag !== e.mag || o.cyc !== e.cyc) begin n_fail++; $display("FAIL corner_peak: got idx=%0d mag=%0d cyc=%0d, want idx=%0d mag=%0d cyc=%0d", o.idx, o.mag, o.cyc, e.idx, e.mag, e.cyc); end
      end
      pk_rd = obs_pk.size(); err_rd = obs_err.size(); exp_pk.delete();
   endtask

   task automatic test_mag();
      pk_t e, o;
      for (int i = 0; i < NBINS; i++) begin
         if (i == 3)      send_bin(i, 300, -400);
         else if (i == 6) send_bin(i, 0, 549);
         else             send_bin(i, 0, 0);
      end
      exp_pk.push_back('{cyc + 4, 3, 550});
      idle(7);
      n_chk++;
      if (obs_pk.size() - pk_rd !== exp_pk.size()) begin n_fail++; $display("FAIL mag_npeak: got %0d pulses, want %0d", obs_pk.size() - pk_rd, exp_pk.size()); end
      while (exp_pk.size() > 0 && pk_rd < obs_pk.size()) begin
         e = exp_pk.pop_front(); o = obs_pk[pk_rd]; pk_rd++;
         n_chk++;
         if (o.idx !== e.idx || o.mag !== e.mag || o.cyc !== e.cyc) begin n_fail++; $display("FAIL mag_peak: got idx=%0d mag=%0d cyc=%0d, want idx=%0d mag=%0d cyc=%0d", o.idx, o.mag, o.cyc, e.idx, e.mag, e.cyc); end
      end
      pk_rd = obs_pk.size(); err_rd = obs_err.size(); exp_pk.delete();
   endtask

   task automatic test_restart();
      pk_t e, o;
      int  ec;
      send_bin(0, 0, 0);
      send_bin(1, 30000, 0);
      send_bin(2, 0, -31000);
      for (int i = 0; i < NBINS; i++) begin
         fr_re[i] = int'($urandom_range(2000, 0)) - 1000;
         fr_im[i] = int'($urandom_range(2000, 0)) - 1000;
      end
      // the error is reported against the second bin 0
      send_bin(0, fr_re[0], fr_im[0]);
      exp_err.push_back(cyc + 3);
      for (int i = 1; i < NBINS; i++) send_bin(i, fr_re[i], fr_im[i]);
      begin
         int first, best, bi, m;
         first = 0;
`ifdef FFT_PEAK_SKIP_DC_EN
         first = 1;
`endif
         best = mag_m(fr_re[first], fr_im[first]);
         bi   = first;
         for (int i = first + 1; i < NBINS; i++) begin
            m = mag_m(fr_re[i], fr_im[i]);
            if (m > best) begin best = m; bi = i; end
         end
         exp_pk.push_back('{cyc + 4, bi, best});
      end
      idle(7);
      n_chk++;
      if (obs_pk.size() - pk_rd !== exp_pk.size()) begin n_fail++; $display("FAIL restart_npeak: got %0d pulses, want %0d", obs_pk.size() - pk_rd, exp_pk.size()); end
      while (exp_pk.size() > 0 && pk_rd < obs_pk.size()) begin
         e = exp_pk.pop_front(); o = obs_pk[pk_rd]; pk_rd++;
         n_chk++;
         if (o.idx !== e.idx || o.mag !== e.mag || o.cyc !== e.cyc) begin n_fail++; $display("FAIL restart_peak: got idx=%0d mag=%0d cyc=%0d, want idx=%0d mag=%0d cyc=%0d", o.idx, o.mag, o.cyc, e.idx, e.mag, e.cyc); end
      end
      n_chk++;
      if (obs_err.size() - err_rd !== exp_err.size()) begin n_fail++; $display("FAIL restart_nerr: got %0d frame_err, want %0d", obs_err.size() - err_rd, exp_err.size()); end
      while (exp_err.size() > 0 && err_rd < obs_err.size()) begin
         ec = exp_err.pop_front();
         n_chk++;
         if (obs_err[err_rd] !== ec) begin n_fail++; $display("FAIL restart_err_cyc: got %0d, want %0d", obs_err[err_rd], ec); end
         err_rd++;
      end
      pk_rd = obs_pk.size(); err_rd = obs_err.size(); exp_pk.delete(); exp_err.delete();
   endtask

   task automatic test_bad_seq();
      int ec;
      send_bin(0, 5000, 0);
      send_bin(1, 6000, 0);
      send_bin(3, 7000, 0);
      exp_err.push_back(cyc + 3);
      for (int i = 4; i < NBINS; i++) send_bin(i, 8000, 0);
      idle(7);
      n_chk++;
      if (obs_pk.size() - pk_rd !== 0) begin n_fail++; $display("FAIL badseq_npeak: got %0d pulses, want 0", obs_pk.size() - pk_rd); end
      n_chk++;
      if (obs_err.size() - err_rd !== exp_err.size()) begin n_fail++; $display("FAIL badseq_nerr: got %0d frame_err, want %0d", obs_err.size() - err_rd, exp_err.size()); end
      while (exp_err.size() > 0 && err_rd < obs_err.size()) begin
         ec = exp_err.pop_front();
         n_chk++;
         if (obs_err[err_rd] !== ec) begin n_fail++; $display("FAIL badseq_err_cyc: got %0d, want %0d", obs_err[err_rd], ec); end
         err_rd++;
      end
      pk_rd = obs_pk.size(); err_rd = obs_err.size(); exp_err.delete();
   endtask

   task automatic test_reset_mid();
      pk_t e, o;
      for (int i = 0; i < 5; i++) send_bin(i, (i == 2) ? 32000 : 10, 0);
      @(negedge fastclk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      idle(2);
      n_chk++;
      if (peak_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got peak_valid=%b frame_err=%b, want 0 0", peak_valid, frame_err); end
      n_chk++;
      if (peak_index !== '0 || peak_mag !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got idx=%0d mag=%0d, want 0 0", peak_index, peak_mag); end
      @(negedge fastclk);
      rst_n = 1'b1;
      idle(2);
      for (int i = 0; i < NBINS; i++) begin
         fr_re[i] = 100 * i + 50;
         fr_im[i] = (i == 6) ? -1234 : 20;
      end
      send_frame_model();
      idle(7);
      n_chk++;
      if (obs_pk.size() - pk_rd !== exp_pk.size()) begin n_fail++; $display("FAIL rstmid_npeak: got %0d pulses, want %0d", obs_pk.size() - pk_rd, exp_pk.size()); end
      while (exp_pk.size() > 0 && pk_rd < obs_pk.size()) begin
         e = exp_pk.pop_front(); o = obs_pk[pk_rd]; pk_rd++;
         n_chk++;
         if (o.idx !== e.idx || o.mag !== e.mag || o.cyc !== e.cyc) begin n_fail++; $display("FAIL rstmid_peak: got idx=%0d mag=%0d cyc=%0d, want idx=%0d mag=%0d cyc=%0d", o.idx, o.mag, o.cyc, e.idx, e.mag, e.cyc); end
      end
      n_chk++;
      if (obs_err.size() - err_rd !== 0) begin n_fail++; $display("FAIL rstmid_nerr: got %0d frame_err, want 0", obs_err.size() - err_rd); end
      pk_rd = obs_pk.size(); err_rd = obs_err.size(); exp_pk.delete();
   endtask

   task automatic test_back_to_back();
      pk_t e, o;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < NBINS; i++) begin
            fr_re[i] = int'($urandom_range(65535, 0)) - 32768;
            fr_im[i] = int'($urandom_range(65535, 0)) - 32768;
         end
         send_frame_model();
      end
      idle(7);
      n_chk++;
      if (obs_pk.size() - pk_rd !== exp_pk.size()) begin n_fail++; $display("FAIL b2b_npeak: got %0d pulses, want %0d", obs_pk.size() - pk_rd, exp_pk.size()); end
      while (exp_pk.size() > 0 && pk_rd < obs_pk.size()) begin
         e = exp_pk.pop_front(); o = obs_pk[pk_rd]; pk_rd++;
         n_chk++;
         if (o.idx !== e.idx || o.mag !== e.mag || o.cyc !== e.cyc) begin n_fail++; $display("FAIL b2b_peak: got idx=%0d mag=%0d cyc=%0d, want idx=%0d mag=%0d cyc=%0d", o.idx, o.mag, o.cyc, e.idx, e.mag, e.cyc); end
      end
      n_chk++;
      if (obs_err.size() - err_rd !== 0) begin n_fail++; $display("FAIL b2b_nerr: got %0d frame_err, want 0", obs_err.size() - err_rd); end
      pk_rd = obs_pk.size(); err_rd = obs_err.size(); exp_pk.delete();
   endtask

   initial begin
      test_reset();
      test_tie();
      test_corner();
      test_mag();
      test_restart();
      test_bad_seq();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
